// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and idle levels.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {dp, g..a}; entry 0 is the rightmost byte.
  localparam logic [15:0][7:0] SEG7_HEX_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low g..a segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG7_HEX_LUT[nibble_i][6:0];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display scanner with frame-synchronous input shadowing
// and a blanking guard at the start of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] DIGIT_VALUES,
  input  logic [3:0]  DOT_IN,
  input  logic [3:0]  BLANK,
  output logic [1:0]  SEG_SELECT,
  output logic [7:0]  SEG_OUT,
  output logic [3:0]  DIGIT_OUT,
  output logic        FRAME_DONE
);

  localparam int unsigned    CntW      = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD_CYCLES);
  localparam logic [1:0]     IdxMax    = 2'(NUM_DIGITS - 1);
  localparam logic [3:0]     DigitMask = 4'((1 << NUM_DIGITS) - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_val_q, shadow_val_d;
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic [3:0]      shadow_blank_q, shadow_blank_d;
  logic [7:0]      seg_out_q, seg_out_d;
  logic [3:0]      digit_out_q, digit_out_d;
  logic            frame_done_q, frame_done_d;

  logic       tick;
  logic       wrap;
  logic [3:0] cur_nibble;
  logic [6:0] cur_glyph;

  seg7_hex_decoder u_hex_decoder (
    .nibble_i (cur_nibble),
    .seg_n_o  (cur_glyph)
  );

  always_comb begin
    tick           = ENABLE && (cnt_q == CntMax);
    wrap           = tick && (idx_q == IdxMax);
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;

    if (ENABLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      idx_d = wrap ? 2'd0 : idx_q + 2'd1;
    end
    // Inputs are captured only at frame wrap so a frame never mixes old and new digits.
    if (wrap) begin
      shadow_val_d   = DIGIT_VALUES;
      shadow_dp_d    = DOT_IN;
      shadow_blank_d = BLANK;
    end

    frame_done_d = wrap;
    cur_nibble   = shadow_val_q[{idx_q, 2'b00} +: 4];
    seg_out_d    = {~shadow_dp_q[idx_q], cur_glyph};

    digit_out_d = ANODE_OFF;
    if (ENABLE && (cnt_q >= GuardCnt) && !shadow_blank_q[idx_q]) begin
      digit_out_d = ~(4'b0001 << idx_q) | ~DigitMask;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      shadow_val_q   <= 16'h0000;
      shadow_dp_q    <= 4'h0;
      shadow_blank_q <= 4'h0;
      seg_out_q      <= SEG_OFF;
      digit_out_q    <= ANODE_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      seg_out_q      <= seg_out_d;
      digit_out_q    <= digit_out_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign SEG_SELECT = idx_q;
  assign SEG_OUT    = seg_out_q;
  assign DIGIT_OUT  = digit_out_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: frame-level vector table, hand-written corner sequences and a
// randomized run against a cycle-position model of the scanner.
module tb_seg7_scan_driver;

  localparam int ClkDiv = 8;
  localparam int Guard  = 2;
  localparam int NDig   = 4;
  localparam int Frame  = ClkDiv * NDig;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [15:0] dv;
  logic [3:0]  dp;
  logic [3:0]  bl;
  logic [1:0]  SEG_SELECT;
  logic [7:0]  SEG_OUT;
  logic [3:0]  DIGIT_OUT;
  logic        FRAME_DONE;

  always #5 CLK = ~CLK;

  seg7_scan_driver #(
    .CLK_DIV      (ClkDiv),
    .NUM_DIGITS   (NDig),
    .GUARD_CYCLES (Guard)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .DIGIT_VALUES (dv),
    .DOT_IN       (dp),
    .BLANK        (bl),
    .SEG_SELECT   (SEG_SELECT),
    .SEG_OUT      (SEG_OUT),
    .DIGIT_OUT    (DIGIT_OUT),
    .FRAME_DONE   (FRAME_DONE)
  );

  typedef struct packed {
    logic [15:0] dv;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic [31:0] seg;  // byte s = expected SEG_OUT in slot s
    logic [15:0] an;   // nibble s = expected lit DIGIT_OUT in slot s
  } row_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: position within the frame counted in enabled clock edges, plus the latched frame.
  int          m_t;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_bl;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [7:0] v;
    v = 8'hFF;
    case (n)
      4'h0: v = 8'hC0;  4'h1: v = 8'hF9;  4'h2: v = 8'hA4;  4'h3: v = 8'hB0;
      4'h4: v = 8'h99;  4'h5: v = 8'h92;  4'h6: v = 8'h82;  4'h7: v = 8'hF8;
      4'h8: v = 8'h80;  4'h9: v = 8'h90;  4'hA: v = 8'h88;  4'hB: v = 8'h83;
      4'hC: v = 8'hC6;  4'hD: v = 8'hA1;  4'hE: v = 8'h86;  4'hF: v = 8'h8E;
    endcase
    return v[6:0];
  endfunction

  function automatic row_t make_row(input logic [15:0] v, input logic [3:0] d,
                                    input logic [3:0] b, input logic [31:0] s,
                                    input logic [15:0] a);
    row_t r;
    r.dv = v; r.dp = d; r.bl = b; r.seg = s; r.an = a;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_val = '0; m_dp = '0; m_bl = '0;
  endtask

  // One clock: predict from the pre-edge model state, clock, then compare.
  task automatic cycle();
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd;
    logic [1:0]  e_sel;
    logic [15:0] c_dv;
    logic [3:0]  c_dp, c_bl;
    logic        c_en, c_rst;
    int d, off;
    d = (m_t / ClkDiv) % NDig;
    off = m_t % ClkDiv;
    c_dv = dv; c_dp = dp; c_bl = bl; c_en = ENABLE; c_rst = RESET;
    if (c_rst) begin
      e_seg = 8'hFF; e_an = 4'hF; e_fd = 1'b0;
    end else begin
      e_seg = {~m_dp[d], ref_seg(m_val[d*4 +: 4])};
      e_an  = (c_en && off >= Guard && !m_bl[d]) ? ~(4'b0001 << d) : 4'hF;
      e_fd  = c_en && (m_t == Frame - 1);
    end
    @(posedge CLK);
    #1;
    if (c_rst) model_reset();
    else if (c_en) begin
      if (m_t == Frame - 1) begin
        m_val = c_dv; m_dp = c_dp; m_bl = c_bl;
      end
      m_t = (m_t + 1) % Frame;
    end
    e_sel = 2'((m_t / ClkDiv) % NDig);
    chk("model_seg_out", {8'h0, SEG_OUT}, {8'h0, e_seg});
    chk("model_digit_out", {12'h0, DIGIT_OUT}, {12'h0, e_an});
    chk("model_frame_done", {15'h0, FRAME_DONE}, {15'h0, e_fd});
    chk("model_seg_select", {14'h0, SEG_SELECT}, {14'h0, e_sel});
    chk("no_x", {15'h0, $isunknown({SEG_OUT, DIGIT_OUT, FRAME_DONE, SEG_SELECT})}, 16'h0);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_t != target && n < 200) begin
      cycle();
      n++;
    end
    if (m_t != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_to: position %0d, expected %0d within 200 cycles", m_t, target);
    end
  endtask

  task automatic apply_row(input string name, input row_t r);
    dv = r.dv; dp = r.dp; bl = r.bl;
    cycle();
    run_to(0);
    chk({name, "_frame_done"}, {15'h0, FRAME_DONE}, 16'h1);
    for (int s = 0; s < NDig; s++) begin
      run_to(s * ClkDiv + 5);
      chk({name, "_sel"}, {14'h0, SEG_SELECT}, 16'(s));
      chk({name, "_seg"}, {8'h0, SEG_OUT}, {8'h0, r.seg[s*8 +: 8]});
      chk({name, "_an"}, {12'h0, DIGIT_OUT}, {12'h0, r.an[s*4 +: 4]});
    end
  endtask

  initial begin
    row_t rows [7];
    int   fd_cnt;
    rows[0] = make_row(16'h4321, 4'b0000, 4'b0000, 32'h99_B0_A4_F9, 16'h7BDE);
    rows[1] = make_row(16'hABCD, 4'b0000, 4'b0000, 32'h88_83_C6_A1, 16'h7BDE);
    rows[2] = make_row(16'h4321, 4'b0010, 4'b1000, 32'h99_B0_24_F9, 16'hFBDE);
    rows[3] = make_row(16'h3210, 4'b0000, 4'b0000, 32'hB0_A4_F9_C0, 16'h7BDE);
    rows[4] = make_row(16'h7654, 4'b0000, 4'b0000, 32'hF8_82_92_99, 16'h7BDE);
    rows[5] = make_row(16'hBA98, 4'b0000, 4'b0000, 32'h83_88_90_80, 16'h7BDE);
    rows[6] = make_row(16'hFEDC, 4'b0000, 4'b0000, 32'h8E_86_A1_C6, 16'h7BDE);

    RESET = 1'b1; ENABLE = 1'b0; dv = '0; dp = '0; bl = '0;
    model_reset();
    cycle();
    cycle();
    chk("reset_seg", {8'h0, SEG_OUT}, 16'h00FF);
    chk("reset_an", {12'h0, DIGIT_OUT}, 16'h000F);

    // Async reset in the middle of slot 1 of the all-zero first frame.
    RESET = 1'b0; ENABLE = 1'b1;
    run_to(13);
    chk("first_frame_zero", {8'h0, SEG_OUT}, 16'h00C0);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_seg", {8'h0, SEG_OUT}, 16'h00FF);
    chk("async_rst_an", {12'h0, DIGIT_OUT}, 16'h000F);
    chk("async_rst_sel", {14'h0, SEG_SELECT}, 16'h0);
    chk("async_rst_fd", {15'h0, FRAME_DONE}, 16'h0);
    model_reset();
    cycle();
    RESET = 1'b0;

    // Scan order and one FRAME_DONE per frame.
    apply_row("scan", rows[0]);
    fd_cnt = 0;
    for (int i = 0; i < Frame; i++) begin
      cycle();
      if (FRAME_DONE === 1'b1) fd_cnt++;
    end
    chk("frame_done_per_frame", 16'(fd_cnt), 16'h1);

    // New value mid-frame must not show until the next frame.
    run_to(9);
    dv = 16'hABCD;
    run_to(13);
    chk("tear_d1", {8'h0, SEG_OUT}, 16'h00A4);
    run_to(21);
    chk("tear_d2", {8'h0, SEG_OUT}, 16'h00B0);
    run_to(29);
    chk("tear_d3", {8'h0, SEG_OUT}, 16'h0099);
    apply_row("tear_next", rows[1]);

    apply_row("dp_blank", rows[2]);

    // Freeze at idx 2, cnt 5, then resume.
    dp = '0; bl = '0;
    run_to(21);
    ENABLE = 1'b0;
    cycle();
    chk("freeze_an_off", {12'h0, DIGIT_OUT}, 16'h000F);
    for (int i = 0; i < 19; i++) begin
      cycle();
      chk("freeze_sel", {14'h0, SEG_SELECT}, 16'h2);
      chk("freeze_no_fd", {15'h0, FRAME_DONE}, 16'h0);
    end
    ENABLE = 1'b1;
    cycle();
    cycle();
    chk("resume_sel_held", {14'h0, SEG_SELECT}, 16'h2);
    cycle();
    chk("resume_sel_next", {14'h0, SEG_SELECT}, 16'h3);

    for (int i = 3; i < 7; i++) apply_row("sweep", rows[i]);

    // Randomized inputs, enable gaps and occasional resets.
    for (int i = 0; i < 1000; i++) begin
      dv     = 16'($urandom);
      dp     = 4'($urandom);
      bl     = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      ENABLE = ($urandom_range(0, 5) != 0);
      RESET  = ($urandom_range(0, 199) == 0);
      cycle();
    end
    RESET = 1'b0;
    ENABLE = 1'b1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
